// File: rtl/snn_epoch_scorer.sv
// rtl/snn_epoch_scorer.sv - scores first-spike SNN predictions against one-hot labels per sample and epoch.
// Result, epoch and best-epoch registers load on the edge into SCORE so they are visible during SCORE.
module snn_epoch_scorer #(
  parameter int p_samples_per_epoch = 10,
  parameter int p_window            = 200,
  parameter int p_epochs            = 400,
  localparam int CW = $clog2(p_samples_per_epoch + 1),
  localparam int EW = $clog2(p_epochs + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [25:1]   i_test_vector,
  input  logic [10:1]   i_label,
  input  logic [10:1]   i_out_spike,
  input  logic          i_end_of_epochs,
  output logic          o_busy,
  output logic          o_result_valid,
  output logic          o_correct,
  output logic [10:1]   o_pred,
  output logic [25:1]   o_last_vector,
  output logic          o_epoch_done,
  output logic [CW-1:0] o_epoch_correct,
  output logic [CW-1:0] o_best_correct,
  output logic [EW-1:0] o_epoch_count,
  output logic          o_overrun,
  output logic          o_done
);

  localparam int WW = (p_window > 1) ? $clog2(p_window) : 1;
  localparam logic [WW-1:0] WIN_LAST = WW'(p_window - 1);
  localparam logic [CW-1:0] SPE      = CW'(p_samples_per_epoch);
  localparam logic [EW-1:0] EPOCHS   = EW'(p_epochs);

  typedef enum logic [1:0] {IDLE, WINDOW, SCORE, FINISHED} state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] cnt_q, cnt_d;
  logic [10:1]   label_q, label_d;
  logic [10:1]   pred_q, pred_d;
  logic [25:1]   vec_q, vec_d;
  logic          correct_q, correct_d;
  logic [CW-1:0] run_q, run_d, sample_q, sample_d;
  logic [CW-1:0] epc_q, epc_d, best_q, best_d;
  logic [EW-1:0] ecnt_q, ecnt_d;
  logic          edone_q, edone_d;
  logic          ovr_q, ovr_d;

  logic [10:1]   lowest, pred_new;
  logic          correct_new;
  logic [CW-1:0] run_inc, sample_inc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      label_q   <= '0;
      pred_q    <= '0;
      vec_q     <= '0;
      correct_q <= 1'b0;
      run_q     <= '0;
      sample_q  <= '0;
      epc_q     <= '0;
      best_q    <= '0;
      ecnt_q    <= '0;
      edone_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      label_q   <= label_d;
      pred_q    <= pred_d;
      vec_q     <= vec_d;
      correct_q <= correct_d;
      run_q     <= run_d;
      sample_q  <= sample_d;
      epc_q     <= epc_d;
      best_q    <= best_d;
      ecnt_q    <= ecnt_d;
      edone_q   <= edone_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    label_d     = label_q;
    pred_d      = pred_q;
    vec_d       = vec_q;
    correct_d   = correct_q;
    run_d       = run_q;
    sample_d    = sample_q;
    epc_d       = epc_q;
    best_d      = best_q;
    ecnt_d      = ecnt_q;
    edone_d     = 1'b0;
    ovr_d       = ovr_q;
    // Two's-complement trick isolates the lowest set spike bit.
    lowest      = i_out_spike & (~i_out_spike + 10'd1);
    pred_new    = (pred_q == '0) ? lowest : pred_q;
    correct_new = (pred_new == label_q) && (pred_new != '0);
    run_inc     = run_q + CW'(correct_new);
    sample_inc  = sample_q + CW'(1);

    case (state_q)
      IDLE: begin
        if (i_label != '0) begin
          label_d = i_label;
          vec_d   = i_test_vector;
          pred_d  = '0;
          cnt_d   = '0;
          state_d = WINDOW;
        end else if (i_end_of_epochs) begin
          state_d = FINISHED;
        end
      end
      WINDOW: begin
        if (i_label != '0) ovr_d = 1'b1;
        pred_d = pred_new;
        cnt_d  = cnt_q + WW'(1);
        if (cnt_q == WIN_LAST) begin
          state_d   = SCORE;
          correct_d = correct_new;
          if (sample_inc == SPE) begin
            epc_d    = run_inc;
            best_d   = (run_inc > best_q) ? run_inc : best_q;
            if (ecnt_q != EPOCHS) ecnt_d = ecnt_q + EW'(1);
            run_d    = '0;
            sample_d = '0;
            edone_d  = 1'b1;
          end else begin
            run_d    = run_inc;
            sample_d = sample_inc;
          end
        end
      end
      SCORE:    state_d = IDLE;
      FINISHED: state_d = FINISHED;
      default:  state_d = IDLE;
    endcase
  end

  assign o_busy          = (state_q == WINDOW);
  assign o_result_valid  = (state_q == SCORE);
  assign o_done          = (state_q == FINISHED);
  assign o_correct       = correct_q;
  assign o_pred          = pred_q;
  assign o_last_vector   = vec_q;
  assign o_epoch_done    = edone_q;
  assign o_epoch_correct = epc_q;
  assign o_best_correct  = best_q;
  assign o_epoch_count   = ecnt_q;
  assign o_overrun       = ovr_q;

endmodule

// File: doc/snn_epoch_scorer.md
# snn_epoch_scorer

Receive-side counterpart of the training stimulus generator. It watches each one-cycle sample pulse (input spike vector plus one-hot label) and opens a fixed response window on the SNN output layer. It takes the first output spike as the network's prediction and scores it against the label. It keeps per-epoch and best-epoch correct counts, and raises a completion flag after the stimulus source reports end of epochs.

## Interface
- p_samples_per_epoch, 10, samples that make up one epoch
- p_window, 200, response window length in cycles (≥1)
- p_epochs, 400, epoch count at which o_epoch_count saturates
- i_clk  input  1  clock; all state updates on the rising edge
- i_rst_n  input  1  asynchronous, active-low reset
- i_test_vector  input  [25:1]  input spike vector; informational, captured into o_last_vector
- i_label  input  [10:1]  one-hot label; a nonzero value is a sample-start strobe
- i_out_spike  input  [10:1]  SNN output-layer spikes, bit k = class k
- i_end_of_epochs  input  1  level from stimulus source, all epochs issued
- o_busy  output  1  response window open
- o_result_valid  output  1  one-cycle pulse when a sample is scored
- o_correct  output  1  score of the sample, valid with o_result_valid
- o_pred  output  [10:1]  captured one-hot prediction, 0 if no spike
- o_last_vector  output  [25:1]  i_test_vector captured at the last sample start
- o_epoch_done  output  1  one-cycle pulse on the last sample of an epoch
- o_epoch_correct  output  [$clog2(p_samples_per_epoch+1)-1:0]  correct count of the last completed epoch
- o_best_correct  output  same width  maximum o_epoch_correct so far
- o_epoch_count  output  [$clog2(p_epochs+1)-1:0]  completed epochs, saturating at p_epochs
- o_overrun  output  1  sticky; a sample start arrived while o_busy
- o_done  output  1  sticky; scoring finished

## Operation
States: IDLE, WINDOW, SCORE, FINISHED.
- IDLE: i_label != 0 → latch label into r_label, latch i_test_vector into o_last_vector, clear r_pred, clear window counter → WINDOW. Otherwise, if i_end_of_epochs=1 → FINISHED.
- WINDOW (o_busy=1): counts cycles 1..p_window.
  - The first cycle with i_out_spike != 0 while r_pred==0 captures the lowest-index set bit only, as a one-hot value. Later spikes are ignored.
  - After the p_window-th cycle → SCORE.
  - A nonzero i_label in WINDOW is ignored for scoring and sets o_overrun.
- SCORE (one cycle): o_result_valid=1; o_correct = (r_pred == r_label) and r_pred != 0.
  - Running count r_run increments if correct; r_sample increments.
  - If r_sample reaches p_samples_per_epoch: o_epoch_correct ← r_run including this sample; o_best_correct ← max(old best, new value); o_epoch_count increments (saturating); r_run and r_sample clear; o_epoch_done=1.
  - Next state is IDLE.
- FINISHED: o_done=1, terminal until reset. Further labels are ignored.
- A spike in the same cycle as the label is not sampled; sampling starts the next cycle.
- A multi-hot label is never correct, because the prediction is always one-hot or zero.
- No spike in the window → o_pred=0, incorrect.
- A partial epoch at FINISHED entry is discarded; o_epoch_correct keeps the last completed value.
- Counter arithmetic is unsigned. r_run ≤ p_samples_per_epoch by construction, so no wrap.

## Timing
- Reset: every output is 0 and state is IDLE. Asserting reset mid-window aborts the sample; no result is produced.
- Label strobe at cycle T:
  - o_busy is high T+1..T+p_window.
  - Spikes are sampled T+1..T+p_window.
  - o_result_valid, o_correct and o_pred are valid at T+p_window+1.
  - o_epoch_done, o_epoch_correct and o_best_correct update in that same cycle.
- The earliest accepted next label is T+p_window+2 (back in IDLE). A label at T+p_window+1 is silently dropped and does not set o_overrun.
- o_pred holds until the next sample start. o_correct holds until the next result.
- o_done rises one cycle after IDLE sees i_end_of_epochs=1.

## Test plan
- p_window=8, p_samples_per_epoch=3. Label 10'b0000000100 at T, spike bit 3 at T+2 → o_result_valid at T+9, o_correct=1, o_pred=10'b0000000100.
- Same cycle T+2 spikes on bits 3 and 5 → o_pred bit 3 only. Spike bit 7 at T+4 only → o_pred bit 7, o_correct=0. No spikes → o_pred=0, o_correct=0.
- Spike at T only, plus spike at T+9 → both ignored, o_pred=0. Spike at T+8 → captured.
- Three samples scored correct, incorrect, correct → o_epoch_done once, o_epoch_correct=2, o_best_correct=2, o_epoch_count=1. Next epoch 1/3 → o_epoch_correct=1, o_best_correct=2.
- Label at T+5 during a window → o_overrun=1, first sample result unchanged.
- p_epochs=2 over 3 epochs → o_epoch_count stays 2. Raise i_end_of_epochs in IDLE → o_done=1 next cycle and later labels ignored. Pulse i_rst_n low mid-window → all outputs 0, no o_result_valid.
